// File: rtl/filter_pkg.sv
// Shared definitions for the frame controller: FSM encoding, statistic width
// and the default per-line acknowledge timeout.
package filter_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_REQ,
    ST_NEXT,
    ST_DONE
  } state_e;

  localparam int unsigned STAT_W          = 32;
  localparam int unsigned ACK_TIMEOUT_DEF = 65535;

endpackage

// File: rtl/filter_frame_stats.sv
// Frame statistics: running cycle counter, last frame length, accumulated
// frame length and frame count.
module filter_frame_stats
  import filter_pkg::*;
(
  input  logic              pclk,
  input  logic              prst,
  input  logic              clear_i,
  input  logic              count_i,
  input  logic              done_i,
  output logic [STAT_W-1:0] frame_cycle_o,
  output logic [STAT_W-1:0] frame_cycle_sum_o,
  output logic [STAT_W-1:0] frame_number_o
);

  logic [STAT_W-1:0] cnt_q, cnt_d;
  logic [STAT_W-1:0] cyc_q, cyc_d;
  logic [STAT_W-1:0] sum_q, sum_d;
  logic [STAT_W-1:0] num_q, num_d;
  logic [STAT_W-1:0] cnt_inc;

  assign cnt_inc = cnt_q + STAT_W'(1);

  always_comb begin
    cnt_d = cnt_q;
    cyc_d = cyc_q;
    sum_d = sum_q;
    num_d = num_q;
    if (clear_i) begin
      cnt_d = '0;
    end else if (count_i) begin
      cnt_d = cnt_inc;
    end
    // The DONE cycle itself is part of the frame length.
    if (done_i) begin
      cyc_d = cnt_inc;
      sum_d = sum_q + cnt_inc;
      num_d = num_q + STAT_W'(1);
    end
  end

  always_ff @(posedge pclk) begin
    if (prst) begin
      cnt_q <= '0;
      cyc_q <= '0;
      sum_q <= '0;
      num_q <= '0;
    end else begin
      cnt_q <= cnt_d;
      cyc_q <= cyc_d;
      sum_q <= sum_d;
      num_q <= num_d;
    end
  end

  assign frame_cycle_o     = cyc_q;
  assign frame_cycle_sum_o = sum_q;
  assign frame_number_o    = num_q;

endmodule

// File: rtl/filter_frame_ctrl.sv
// Frame controller: walks a frame line by line, handing one line descriptor
// at a time to the line engine and collecting per-frame statistics.
module filter_frame_ctrl
  import filter_pkg::*;
#(
  parameter int unsigned ACK_TIMEOUT = ACK_TIMEOUT_DEF
) (
  input  logic        pclk,
  input  logic        prst,
  input  logic        frame_start,
  input  logic [15:0] frame_width,
  input  logic [15:0] frame_height,
  input  logic [31:0] baseImageI,
  input  logic [31:0] baseImageO,
  input  logic        pixel_size,
  output logic        line_req,
  input  logic        line_ack,
  output logic [31:0] line_rd_addr,
  output logic [31:0] line_wr_addr,
  output logic [15:0] line_len,
  output logic [15:0] line_idx,
  output logic        frame_done,
  output logic [31:0] frame_number,
  output logic [31:0] frame_cycle,
  output logic [31:0] frame_cycle_sum,
  output logic        busy,
  output logic        err
);

  localparam logic [31:0] WAIT_LAST = 32'(ACK_TIMEOUT - 1);

  state_e      state_q, state_d;
  logic [15:0] width_q, width_d;
  logic [15:0] height_q, height_d;
  logic [31:0] base_i_q, base_i_d;
  logic [31:0] base_o_q, base_o_d;
  logic        psize_q, psize_d;
  logic [16:0] stride_q, stride_d;
  logic [31:0] rd_q, rd_d;
  logic [31:0] wr_q, wr_d;
  logic [15:0] idx_q, idx_d;
  logic [31:0] wait_q, wait_d;
  logic        err_q, err_d;
  logic        start_acc;

  always_comb begin
    state_d   = state_q;
    width_d   = width_q;
    height_d  = height_q;
    base_i_d  = base_i_q;
    base_o_d  = base_o_q;
    psize_d   = psize_q;
    stride_d  = stride_q;
    rd_d      = rd_q;
    wr_d      = wr_q;
    idx_d     = idx_q;
    wait_d    = wait_q;
    err_d     = err_q;
    start_acc = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (frame_start) begin
          start_acc = 1'b1;
          width_d   = frame_width;
          height_d  = frame_height;
          base_i_d  = baseImageI;
          base_o_d  = baseImageO;
          psize_d   = pixel_size;
          err_d     = 1'b0;
          state_d   = ST_LOAD;
        end
      end
      ST_LOAD: begin
        stride_d = {1'b0, width_q} << psize_q;
        rd_d     = base_i_q;
        wr_d     = base_o_q;
        idx_d    = '0;
        wait_d   = '0;
        state_d  = (width_q == '0 || height_q == '0) ? ST_DONE : ST_REQ;
      end
      ST_REQ: begin
        // Acknowledge wins even in the last allowed wait cycle.
        if (line_ack) begin
          state_d = ST_NEXT;
        end else if (wait_q == WAIT_LAST) begin
          err_d   = 1'b1;
          state_d = ST_DONE;
        end else begin
          wait_d = wait_q + 32'd1;
        end
      end
      ST_NEXT: begin
        rd_d    = rd_q + {15'd0, stride_q};
        wr_d    = wr_q + {15'd0, stride_q};
        idx_d   = idx_q + 16'd1;
        wait_d  = '0;
        state_d = (idx_q == height_q - 16'd1) ? ST_DONE : ST_REQ;
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge pclk) begin
    if (prst) begin
      state_q  <= ST_IDLE;
      width_q  <= '0;
      height_q <= '0;
      base_i_q <= '0;
      base_o_q <= '0;
      psize_q  <= 1'b0;
      stride_q <= '0;
      rd_q     <= '0;
      wr_q     <= '0;
      idx_q    <= '0;
      wait_q   <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      width_q  <= width_d;
      height_q <= height_d;
      base_i_q <= base_i_d;
      base_o_q <= base_o_d;
      psize_q  <= psize_d;
      stride_q <= stride_d;
      rd_q     <= rd_d;
      wr_q     <= wr_d;
      idx_q    <= idx_d;
      wait_q   <= wait_d;
      err_q    <= err_d;
    end
  end

  filter_frame_stats u_stats (
    .pclk              (pclk),
    .prst              (prst),
    .clear_i           (start_acc),
    .count_i           (state_q != ST_IDLE),
    .done_i            (state_q == ST_DONE),
    .frame_cycle_o     (frame_cycle),
    .frame_cycle_sum_o (frame_cycle_sum),
    .frame_number_o    (frame_number)
  );

  assign line_req     = (state_q == ST_REQ);
  assign frame_done   = (state_q == ST_DONE);
  assign busy         = (state_q != ST_IDLE);
  assign line_rd_addr = rd_q;
  assign line_wr_addr = wr_q;
  assign line_len     = width_q;
  assign line_idx     = idx_q;
  assign err          = err_q;

endmodule
